// File: rtl/sdram_bridge_pkg.sv
// Shared types, widths and byte-lane helpers for the CPU-to-SDRAM byte bridge.
package sdram_bridge_pkg;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned WADDR_W = 23;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WDOG_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  // Pick the addressed byte: a0=0 is the low byte, a0=1 the high byte.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w, input logic a0);
    return a0 ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] w,
                                                   input logic [BYTE_W-1:0] b,
                                                   input logic a0);
    return a0 ? {b, w[7:0]} : {w[15:8], b};
  endfunction

endpackage

// File: rtl/sdram_bridge_cache.sv
// One-word read cache: tag/data/valid with lookup, fill, byte merge and invalidate.
module sdram_bridge_cache
  import sdram_bridge_pkg::*;
(
  input  logic                clk,
  input  logic                init_n,
  input  logic [WADDR_W-1:0]  lookup_tag,
  output logic                hit_c,
  output logic [WORD_W-1:0]   data,
  input  logic                fill_en,
  input  logic                fill_valid,
  input  logic [WADDR_W-1:0]  fill_tag,
  input  logic [WORD_W-1:0]   fill_data,
  input  logic                merge_en,
  input  logic [BYTE_W-1:0]   merge_byte,
  input  logic                merge_a0,
  input  logic                inv
);

  logic               valid;
  logic [WADDR_W-1:0] tag;

  assign hit_c = valid && (tag == lookup_tag);

  // Invalidate is applied last so it wins over a same-cycle fill.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (fill_en) begin
        tag   <= fill_tag;
        data  <= fill_data;
        valid <= fill_valid;
      end else if (merge_en) begin
        data <= byte_merge(data, merge_byte, merge_a0);
      end
      if (inv) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_byte_bridge.sv
// 8-bit CPU bus to 16-bit toggle-handshake SDRAM controller port, with a
// one-word read cache and a watchdog for accesses that never get acked.
module sdram_byte_bridge
  import sdram_bridge_pkg::*;
#(
  parameter bit          CACHE_EN = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  input  logic        cache_inv,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        mem_we,
  output logic [22:0] mem_a,
  output logic [1:0]  mem_ds,
  output logic [15:0] mem_d,
  input  logic [15:0] mem_q
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [WDOG_W-1:0]   wdog, wdog_nxt;
  logic                a0, a0_nxt;
  logic                mem_req_nxt, mem_we_nxt;
  logic [WADDR_W-1:0]  mem_a_nxt;
  logic [1:0]          mem_ds_nxt;
  logic [WORD_W-1:0]   mem_d_nxt;
  logic [BYTE_W-1:0]   cpu_q_nxt;
  logic                cpu_busy_nxt, cpu_done_nxt, cpu_err_nxt;

  logic                hit_c, read_hit_c, ack_c, timeout_c;
  logic                fill_en_c, merge_en_c, inv_c;
  logic [WADDR_W-1:0]  lookup_tag_c;
  logic [WORD_W-1:0]   cache_data;

  // In IDLE the cache is probed with the incoming address, in WAIT with the latched one.
  assign lookup_tag_c = (state == WAIT) ? mem_a : cpu_a[ADDR_W-1:1];
  assign read_hit_c   = cpu_req && !cpu_we && CACHE_EN && hit_c;
  assign ack_c        = (mem_ack == mem_req);
  assign timeout_c    = (state == WAIT) && !ack_c && (wdog == WDOG_LAST);
  assign inv_c        = cache_inv || timeout_c;

  sdram_bridge_cache u_cache (
    .clk        (clk),
    .init_n     (init_n),
    .lookup_tag (lookup_tag_c),
    .hit_c      (hit_c),
    .data       (cache_data),
    .fill_en    (fill_en_c),
    .fill_valid (CACHE_EN),
    .fill_tag   (mem_a),
    .fill_data  (mem_q),
    .merge_en   (merge_en_c),
    .merge_byte (mem_d[7:0]),
    .merge_a0   (a0),
    .inv        (inv_c)
  );

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= IDLE;
      wdog     <= '0;
      a0       <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_ds   <= 2'b00;
      mem_d    <= '0;
      cpu_q    <= '0;
      cpu_busy <= 1'b0;
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wdog     <= wdog_nxt;
      a0       <= a0_nxt;
      mem_req  <= mem_req_nxt;
      mem_we   <= mem_we_nxt;
      mem_a    <= mem_a_nxt;
      mem_ds   <= mem_ds_nxt;
      mem_d    <= mem_d_nxt;
      cpu_q    <= cpu_q_nxt;
      cpu_busy <= cpu_busy_nxt;
      cpu_done <= cpu_done_nxt;
      cpu_err  <= cpu_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cpu_req && !read_hit_c) state_nxt = WAIT;
      WAIT: if (ack_c || timeout_c)     state_nxt = IDLE;
    endcase
  end

  // Ack has priority over the watchdog when both land in the same cycle.
  always_comb begin
    wdog_nxt     = wdog;
    a0_nxt       = a0;
    mem_req_nxt  = mem_req;
    mem_we_nxt   = mem_we;
    mem_a_nxt    = mem_a;
    mem_ds_nxt   = mem_ds;
    mem_d_nxt    = mem_d;
    cpu_q_nxt    = cpu_q;
    cpu_busy_nxt = cpu_busy;
    cpu_done_nxt = 1'b0;
    cpu_err_nxt  = 1'b0;
    fill_en_c    = 1'b0;
    merge_en_c   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (read_hit_c) begin
            cpu_q_nxt    = byte_sel(cache_data, cpu_a[0]);
            cpu_done_nxt = 1'b1;
          end else begin
            a0_nxt       = cpu_a[0];
            mem_a_nxt    = cpu_a[ADDR_W-1:1];
            mem_we_nxt   = cpu_we;
            mem_d_nxt    = {cpu_d, cpu_d};
            mem_ds_nxt   = !cpu_we ? DS_WORD : (cpu_a[0] ? DS_HI : DS_LO);
            mem_req_nxt  = !mem_req;
            cpu_busy_nxt = 1'b1;
            wdog_nxt     = '0;
          end
        end
      end
      WAIT: begin
        wdog_nxt = wdog + WDOG_W'(1);
        if (ack_c) begin
          if (!mem_we) begin
            cpu_q_nxt = byte_sel(mem_q, a0);
            fill_en_c = 1'b1;
          end else begin
            merge_en_c = hit_c;
          end
          cpu_done_nxt = 1'b1;
          cpu_busy_nxt = 1'b0;
        end else if (timeout_c) begin
          cpu_done_nxt = 1'b1;
          cpu_err_nxt  = 1'b1;
          cpu_busy_nxt = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_byte_bridge.sv
// Self-checking bench for sdram_byte_bridge: behavioural controller model plus
// a CPU-level memory/cache reference.
module tb_sdram_byte_bridge;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        init_n;
  logic        cpu_req, cpu_we;
  logic [23:0] cpu_a;
  logic [7:0]  cpu_d, cpu_q;
  logic        cpu_busy, cpu_done, cpu_err;
  logic        cache_inv;
  logic        mem_req, mem_ack, mem_we;
  logic [22:0] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d, mem_q;

  int n_checks = 0;
  int n_errors = 0;

  // Controller-side storage (written from DUT strobes) and CPU-side reference.
  logic [15:0] sdram   [int unsigned];
  logic [15:0] ref_mem [int unsigned];

  bit          ack_en;
  bit          inv_on_ack;
  bit          mvalid;
  logic [22:0] mtag;

  sdram_byte_bridge #(.CACHE_EN(1'b1), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_a     (cpu_a),
    .cpu_d     (cpu_d),
    .cpu_q     (cpu_q),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .cache_inv (cache_inv),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_ds    (mem_ds),
    .mem_d     (mem_d),
    .mem_q     (mem_q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [22:0] wa);
    int unsigned k;
    k = 32'(wa);
    return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
  endfunction

  // Controller model: acks a pending toggle after 0..3 extra cycles.
  initial begin
    int lat;
    int ack_lat;
    int unsigned k;
    logic [15:0] w;
    lat = 0;
    ack_lat = 0;
    mem_ack = 1'b0;
    mem_q = 16'h0000;
    cache_inv = 1'b0;
    forever begin
      @(negedge clk);
      cache_inv = 1'b0;
      if (!init_n) begin
        mem_ack = 1'b0;
        lat = 0;
      end else if (ack_en && (mem_req != mem_ack)) begin
        if (lat < ack_lat) begin
          lat++;
        end else begin
          k = 32'(mem_a);
          w = sdram.exists(k) ? sdram[k] : 16'h0000;
          if (mem_we) begin
            if (mem_ds[0]) w[7:0]  = mem_d[7:0];
            if (mem_ds[1]) w[15:8] = mem_d[15:8];
            sdram[k] = w;
          end
          mem_q = w;
          mem_ack = mem_req;
          cache_inv = inv_on_ack;
          lat = 0;
          ack_lat = int'($urandom_range(0, 3));
        end
      end
    end
  end

  // One CPU access; entered and left at a negedge.
  task automatic access(input logic we, input logic [23:0] a, input logic [7:0] d, input bit exp_to);
    logic        req0, exp_req;
    bit          hit;
    int          n;
    logic [15:0] w;
    logic [7:0]  eb;
    logic [1:0]  eds;
    int unsigned k;
    hit = !we && mvalid && (mtag == a[23:1]);
    w = ref_rd(a[23:1]);
    eb = a[0] ? w[15:8] : w[7:0];
    eds = !we ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    req0 = mem_req;
    exp_req = ~req0;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_a = a;
    cpu_d = d;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we = 1'($urandom);
    cpu_a = 24'($urandom);
    cpu_d = 8'($urandom);
    if (hit) begin
      check_eq("hit_done", 32'(cpu_done), 1);
      check_eq("hit_q", 32'(cpu_q), 32'(eb));
      check_eq("hit_no_toggle", 32'(mem_req), 32'(req0));
      check_eq("hit_busy", 32'(cpu_busy), 0);
    end else begin
      check_eq("miss_toggle", 32'(mem_req), 32'(exp_req));
      check_eq("miss_busy", 32'(cpu_busy), 1);
      check_eq("miss_a", 32'(mem_a), 32'(a[23:1]));
      check_eq("miss_we", 32'(mem_we), 32'(we));
      check_eq("miss_ds", 32'(mem_ds), 32'(eds));
      check_eq("miss_d", 32'(mem_d), 32'({d, d}));
      n = 0;
      while (!cpu_done && n < 40) begin
        cpu_req = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        n++;
      end
      cpu_req = 1'b0;
      check_eq("done_seen", 32'(cpu_done), 1);
      check_eq("err", 32'(cpu_err), 32'(exp_to));
      check_eq("busy_drop", 32'(cpu_busy), 0);
      if (exp_to) check_eq("timeout_cycles", 32'(n), TO);
      if (!we && !exp_to) check_eq("miss_q", 32'(cpu_q), 32'(eb));
    end
    @(negedge clk);
    check_eq("done_pulse", 32'(cpu_done), 0);
    if (exp_to) begin
      mvalid = 1'b0;
    end else if (!we && !hit) begin
      mvalid = !inv_on_ack;
      mtag = a[23:1];
    end
    if (we && !exp_to) begin
      k = 32'(a[23:1]);
      if (a[0]) w[15:8] = d;
      else      w[7:0]  = d;
      ref_mem[k] = w;
    end
  endtask

  initial begin
    int n;
    logic [23:0] ra;
    logic [22:0] wa;
    bit rw;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_a = '0;
    cpu_d = '0;
    ack_en = 1'b1;
    inv_on_ack = 1'b0;
    mvalid = 1'b0;
    mtag = '0;
    init_n = 1'b0;
    for (int j = 0; j < 8; j++) begin
      for (int h = 0; h < 2; h++) begin
        wa = (h == 1 ? 23'h400000 : 23'h000000) | 23'h000100 | 23'(j);
        sdram[32'(wa)] = 16'($urandom);
        ref_mem[32'(wa)] = sdram[32'(wa)];
      end
    end
    for (int j = 0; j < 8; j++) begin
      sdram[32'h180 + 32'(j)] = 16'($urandom);
      ref_mem[32'h180 + 32'(j)] = sdram[32'h180 + 32'(j)];
    end
    sdram[32'h100] = 16'hBEEF;
    ref_mem[32'h100] = 16'hBEEF;

    repeat (3) @(negedge clk);
    check_eq("rst_mem_a", 32'(mem_a), 0);
    check_eq("rst_ctrl", 32'({mem_req, mem_we, mem_ds, cpu_busy, cpu_done, cpu_err}), 0);
    init_n = 1'b1;
    @(negedge clk);

    // Read miss, read hit, write merge, merged read hit.
    access(1'b0, 24'h000201, 8'h00, 1'b0);
    check_eq("tp_miss_q", 32'(cpu_q), 32'h0BE);
    access(1'b0, 24'h000200, 8'h00, 1'b0);
    check_eq("tp_hit_q", 32'(cpu_q), 32'h0EF);
    access(1'b1, 24'h000201, 8'h55, 1'b0);
    access(1'b0, 24'h000201, 8'h00, 1'b0);
    check_eq("tp_merge_q", 32'(cpu_q), 32'h055);

    // Same word with bit 23 set must not hit.
    access(1'b0, 24'h800200, 8'h00, 1'b0);

    // Invalidate coincident with the fill ack: next read of that word misses.
    inv_on_ack = 1'b1;
    access(1'b0, 24'h000302, 8'h00, 1'b0);
    inv_on_ack = 1'b0;
    access(1'b0, 24'h000303, 8'h00, 1'b0);

    for (int i = 0; i < 80; i++) begin
      rw = ($urandom_range(0, 3) == 0);
      wa = (($urandom_range(0, 3) == 0) ? 23'h400000 : 23'h000000) | 23'h000100 | 23'($urandom_range(0, 3));
      ra = {wa, 1'($urandom)};
      access(rw, ra, 8'($urandom), 1'b0);
    end

    // Watchdog: no ack, then a late ack is absorbed before a normal access.
    ack_en = 1'b0;
    access(1'b0, 24'h00030A, 8'h00, 1'b1);
    ack_en = 1'b1;
    n = 0;
    while (mem_ack !== mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("late_ack", 32'(mem_ack == mem_req), 1);
    @(negedge clk);
    access(1'b0, 24'h00030B, 8'h00, 1'b0);
    access(1'b0, 24'h000202, 8'h00, 1'b0);

    // Reset in the middle of WAIT.
    ack_en = 1'b0;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_a = 24'h00030C;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", 32'(cpu_busy), 1);
    init_n = 1'b0;
    #1;
    check_eq("arst_mem_a", 32'(mem_a), 0);
    check_eq("arst_mem_d", 32'(mem_d), 0);
    check_eq("arst_cpu_q", 32'(cpu_q), 0);
    check_eq("arst_ctrl", 32'({mem_req, mem_we, mem_ds, cpu_busy, cpu_done, cpu_err}), 0);
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    mvalid = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(cpu_busy), 0);
    check_eq("post_rst_done", 32'(cpu_done), 0);
    access(1'b0, 24'h000201, 8'h00, 1'b0);
    check_eq("post_rst_req", 32'(mem_req), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_byte_bridge.md
Name: sdram_byte_bridge

Overview:
- Converts the 8-bit CPU memory bus into one 16-bit toggle-handshake port of the dual-port SDRAM controller.
- One instance sits in front of port1 (CPU, banks 0/1) and a second in front of port2.
- Handles byte-lane selection and the toggle req/ack protocol.
- Holds a one-word read cache so sequential byte reads of the same word skip the SDRAM round trip.
- Includes a watchdog that aborts accesses the controller never acknowledges.

Parameters:
- CACHE_EN, 1: 1 enables the one-word read cache; 0 sends every read to SDRAM.
- TIMEOUT, 255: number of cycles spent in WAIT before the access aborts. Legal range is 16..65535.

Ports:
- clk  in  1  controller clock, the same clock as the SDRAM controller.
- init_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  one-cycle access start pulse.
- cpu_we  in  1  1 = write, 0 = read. Sampled with cpu_req.
- cpu_a  in  24  byte address. Sampled with cpu_req.
- cpu_d  in  8  write data. Sampled with cpu_req.
- cpu_q  out  8  read data, held until the next read completes.
- cpu_busy  out  1  high from the cycle after an accepted cpu_req until cpu_done.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  high with cpu_done when the access timed out.
- cache_inv  in  1  clears the cache (used after a DMA or loader writes through the other port).
- mem_req  out  1  toggle request to the controller port.
- mem_ack  in  1  controller ack; the access is complete when mem_ack == mem_req.
- mem_we  out  1  write enable.
- mem_a  out  23  word address, equal to cpu_a[23:1].
- mem_ds  out  2  byte strobes; bit0 = low byte [7:0], bit1 = high byte [15:8].
- mem_d  out  16  write data, cpu_d replicated on both bytes.
- mem_q  in  16  read data, valid in the cycle where mem_ack == mem_req.

Behaviour:
- Reset (init_n low, asynchronous): state IDLE.
  - Outputs cleared: mem_req=0, mem_we=0, mem_a=0, mem_ds=2'b00, mem_d=0, cpu_q=0, cpu_busy=0, cpu_done=0, cpu_err=0.
  - Cache cleared: valid=0, tag=0, data=0. Watchdog cleared: wdog=0.
  - Reset in the middle of an access abandons it. No cpu_done is issued.
- State IDLE, on cpu_req:
  - Read hit: condition is CACHE_EN && valid && tag==cpu_a[23:1]. cpu_q <= byte of the cached data (cpu_a[0]=0 selects [7:0], 1 selects [15:8]). cpu_done pulses on the next edge. No mem_req toggle; state stays IDLE.
  - Any other case: latch mem_a, mem_we and mem_d={cpu_d,cpu_d}.
    - mem_ds = 2'b11 for a read, 2'b01 for a write with a[0]=0, 2'b10 for a write with a[0]=1.
    - Toggle mem_req, set cpu_busy=1, clear wdog, go to WAIT.
  - mem_a, mem_ds, mem_we and mem_d stay stable until the next accepted request.
- State WAIT:
  - wdog increments every cycle.
  - Completion when mem_ack == mem_req, sampled at the edge:
    - Read: cpu_q <= selected byte of mem_q. Fill the cache (tag=mem_a, data=mem_q, valid=CACHE_EN).
    - Write that hits the cache: merge cpu_d into the addressed byte of the cached data.
    - Write that misses: cache unchanged.
    - Then pulse cpu_done, drop cpu_busy, go to IDLE.
  - Timeout when wdog == TIMEOUT-1 without ack: pulse cpu_done and cpu_err, clear valid, go to IDLE. mem_req is not toggled back.
    - A late ack is absorbed: the next request toggles again and waits for equality.
    - Any mismatch at the next request simply extends that WAIT.
- cpu_req while cpu_busy is high is ignored. No queueing.
- cache_inv clears valid on the next edge.
  - It has priority over a fill or write-merge in the same cycle: valid ends at 0.
  - cache_inv together with a read-hit cpu_req: the hit is still served from the pre-invalidate data.
- Handshake latency:
  - Hit: 1 cycle from cpu_req to cpu_done.
  - Miss: 1 cycle plus the controller's ack latency.
- Widths: wdog is 16 bits; a tag comparison covers all 23 bits.

Decomposition:
- Package sdram_bridge_pkg holds:
  - state enum {IDLE, WAIT};
  - DS_LO=2'b01, DS_HI=2'b10, DS_WORD=2'b11;
  - function byte_sel(word, a0);
  - function byte_merge(word, byte, a0).
- Sub-module sdram_bridge_cache: the one-word tag/data/valid register set with lookup, fill, merge and invalidate ports. The FSM and watchdog stay in the top level.

Test Plan:
- Read miss: SDRAM word 0x000100 = 0xBEEF; cpu_req read at a=0x000201 -> mem_req toggles, mem_ds=11, mem_a=0x000100; ack gives cpu_q=0xBE and one cpu_done pulse.
- Read hit: then read a=0x000200 -> cpu_done 1 cycle later, cpu_q=0xEF, mem_req unchanged.
- Write merge: write 0x55 to a=0x000201 -> mem_ds=10, mem_d=0x5555; after ack, a read of 0x000201 hits with cpu_q=0x55 and no mem_req toggle.
- Invalidate race: cache_inv asserted in the same cycle as the read-fill ack -> a following read of the same word toggles mem_req (miss).
- Timeout: TIMEOUT=16, mem_ack held constant -> cpu_done and cpu_err together 16 cycles after entering WAIT; the next access completes normally once the model acks.
- Reset: init_n low during WAIT -> all outputs 0 immediately; after release, cpu_busy=0 and the first access toggles mem_req 0->1.
